// File: rtl/tick_scheduler_pkg.sv
// Shared constants for tick_scheduler: register map, bit positions and scan FSM encoding.
package tick_scheduler_pkg;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;

    localparam logic [AW-1:0] ADR_CTRL     = 4'h0;
    localparam logic [AW-1:0] ADR_STATUS   = 4'h1;
    localparam logic [AW-1:0] ADR_CHSEL    = 4'h2;
    localparam logic [AW-1:0] ADR_CHCFG    = 4'h3;
    localparam logic [AW-1:0] ADR_RELOAD_L = 4'h4;
    localparam logic [AW-1:0] ADR_RELOAD_H = 4'h5;
    localparam logic [AW-1:0] ADR_COUNT_L  = 4'h6;
    localparam logic [AW-1:0] ADR_COUNT_H  = 4'h7;

    localparam int unsigned CTRL_EN      = 7;
    localparam int unsigned CTRL_OVR_CLR = 0;
    localparam int unsigned STAT_OVR     = 7;
    localparam int unsigned CFG_CEN      = 0;
    localparam int unsigned CFG_PER      = 1;
    localparam int unsigned CFG_IEN      = 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

endpackage

// File: rtl/tick_scheduler_if.sv
// 8-bit Wishbone peripheral bus bundle for tick_scheduler.
interface tick_scheduler_if;
    logic [3:0] WB_ADRi;
    logic [7:0] WB_DATi;
    logic [7:0] WB_DATo;
    logic       WB_WEi;
    logic       WB_CYCi;
    logic       WB_STBi;
    logic       WB_ACKo;

    modport master (output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
                    input  WB_DATo, WB_ACKo);
    modport slave  (input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
                    output WB_DATo, WB_ACKo);
endinterface

// File: rtl/tick_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector; pulse is one clk wide.
module tick_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);
    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= async_in;
            sync2   <= sync1;
            sync2_d <= sync2;
            pulse   <= sync2 & ~sync2_d;
        end
    end
endmodule

// File: rtl/tick_scheduler.sv
// Time-shares one decrementer across NCH software-timer channels, scanning all channels once per tick.
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic SCHED_INT,
    tick_scheduler_if.slave wb
);
    localparam logic [7:0] CH_MASK = 8'((9'd1 << NCH) - 9'd1);

    logic          tick_evt;
    logic [0:0]    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovr_set;

    logic          en_q, ovr_q;
    logic [7:0]    pend_q, cen_q, per_q, ien_q;
    logic [IW-1:0] chsel_q;
    logic [7:0]    stage_q;
    logic [CW-1:0] reload_q [8];
    logic [CW-1:0] count_q  [8];

    logic          bus_act, wr, sel_ok, ch_wr, scan_act, expire;
    logic [7:0]    w1c, pend_set, rd;

    tick_sync_edge u_sync (.clk(clk), .rst(rst), .async_in(tick_in), .pulse(tick_evt));

    assign bus_act     = wb.WB_CYCi & wb.WB_STBi;
    assign wr          = bus_act & wb.WB_WEi;
    assign wb.WB_ACKo  = bus_act;
    assign sel_ok      = (4'(chsel_q) < 4'(NCH));
    assign ch_wr       = wr && sel_ok &&
                         (wb.WB_ADRi == ADR_CHCFG   || wb.WB_ADRi == ADR_RELOAD_H ||
                          wb.WB_ADRi == ADR_COUNT_L || wb.WB_ADRi == ADR_COUNT_H);
    // A software write to the channel being scanned wins; its step is skipped this tick.
    assign scan_act    = (state_q == S_SCAN) && cen_q[idx_q] && !(ch_wr && (chsel_q == idx_q));
    assign expire      = (count_q[idx_q] <= CW'(1));
    assign pend_set    = (scan_act && expire) ? 8'(8'd1 << idx_q) : 8'h00;
    assign w1c         = (wr && wb.WB_ADRi == ADR_STATUS) ? (wb.WB_DATi & CH_MASK) : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_evt && en_q) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (tick_evt && en_q) ovr_set = 1'b1;
                if (idx_q == IW'(NCH - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = IW'(idx_q + 3'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            ovr_q     <= 1'b0;
            pend_q    <= '0;
            cen_q     <= '0;
            per_q     <= '0;
            ien_q     <= '0;
            chsel_q   <= '0;
            stage_q   <= '0;
            SCHED_INT <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                reload_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            if (wr && wb.WB_ADRi == ADR_CTRL) en_q <= wb.WB_DATi[CTRL_EN];
            ovr_q     <= ovr_set | (ovr_q & ~(wr && wb.WB_ADRi == ADR_CTRL && wb.WB_DATi[CTRL_OVR_CLR]));
            pend_q    <= (pend_q & ~w1c) | pend_set;
            SCHED_INT <= |(pend_q & ien_q & CH_MASK);
            if (wr && wb.WB_ADRi == ADR_CHSEL) chsel_q <= wb.WB_DATi[IW-1:0];
            if (wr && sel_ok && wb.WB_ADRi == ADR_RELOAD_L) stage_q <= wb.WB_DATi;

            if (scan_act) begin
                if (expire) begin
                    count_q[idx_q] <= (reload_q[idx_q] == '0) ? CW'(1) : reload_q[idx_q];
                    if (!per_q[idx_q]) cen_q[idx_q] <= 1'b0;
                end else begin
                    count_q[idx_q] <= count_q[idx_q] - CW'(1);
                end
            end

            if (wr && sel_ok && wb.WB_ADRi == ADR_CHCFG) begin
                cen_q[chsel_q] <= wb.WB_DATi[CFG_CEN];
                per_q[chsel_q] <= wb.WB_DATi[CFG_PER];
                ien_q[chsel_q] <= wb.WB_DATi[CFG_IEN];
            end
            if (wr && sel_ok && wb.WB_ADRi == ADR_RELOAD_H) begin
                reload_q[chsel_q] <= CW'({wb.WB_DATi, stage_q});
                count_q[chsel_q]  <= CW'({wb.WB_DATi, stage_q});
            end
        end
    end

    // Read mux; channel windows return 0 when CHSEL is out of range.
    always_comb begin
        rd = 8'h00;
        case (wb.WB_ADRi)
            ADR_CTRL:     rd[CTRL_EN] = en_q;
            ADR_STATUS: begin
                rd           = pend_q & CH_MASK;
                rd[STAT_OVR] = ovr_q;
            end
            ADR_CHSEL:    rd = 8'(chsel_q);
            ADR_CHCFG:    if (sel_ok) rd = {5'b0, ien_q[chsel_q], per_q[chsel_q], cen_q[chsel_q]};
            ADR_RELOAD_L: if (sel_ok) rd = reload_q[chsel_q][7:0];
            ADR_RELOAD_H: if (sel_ok) rd = reload_q[chsel_q][15:8];
            ADR_COUNT_L:  if (sel_ok) rd = count_q[chsel_q][7:0];
            ADR_COUNT_H:  if (sel_ok) rd = count_q[chsel_q][15:8];
            default:      rd = 8'h00;
        endcase
    end

    assign wb.WB_DATo = rd;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: register map, periodic/one-shot expiry, overrun, collisions, reset.
module tb_tick_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic tick_in;
    logic sched_int;
    int   checks = 0;
    int   fails  = 0;
    logic [7:0] d;

    tick_scheduler_if wb ();

    tick_scheduler #(.NCH(4), .CW(16)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .SCHED_INT(sched_int), .wb(wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb.WB_CYCi = 1'b0; wb.WB_STBi = 1'b0; wb.WB_WEi = 1'b0;
        wb.WB_ADRi = 4'h0; wb.WB_DATi = 8'h00;
    endtask

    task automatic bus_wr_set(input logic [3:0] a, input logic [7:0] v);
        wb.WB_CYCi = 1'b1; wb.WB_STBi = 1'b1; wb.WB_WEi = 1'b1;
        wb.WB_ADRi = a; wb.WB_DATi = v;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        @(negedge clk); bus_wr_set(a, v);
        @(negedge clk); bus_idle();
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk);
        wb.WB_CYCi = 1'b1; wb.WB_STBi = 1'b1; wb.WB_WEi = 1'b0; wb.WB_ADRi = a;
        #1 v = wb.WB_DATo;
        bus_idle();
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        chk(tag, 16'(v), 16'(exp));
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick_in pulse, then enough idle time for sync + full scan.
    task automatic tick();
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        negs(10);
    endtask

    initial begin
        rst = 1'b1; tick_in = 1'b0; bus_idle();
        negs(3);
        rst = 1'b0;

        // Reset state
        for (int a = 0; a < 16; a++) rd_chk($sformatf("reset_rd_%0h", a), 4'(a), 8'h00);
        chk("reset_int", 16'(sched_int), 16'h0);
        @(negedge clk);
        wb.WB_CYCi = 1'b1; wb.WB_STBi = 1'b0; #1 chk("ack_cyc_only", 16'(wb.WB_ACKo), 16'h0);
        wb.WB_STBi = 1'b1; #1 chk("ack_cyc_stb", 16'(wb.WB_ACKo), 16'h1);
        wb.WB_CYCi = 1'b0; #1 chk("ack_stb_only", 16'(wb.WB_ACKo), 16'h0);
        bus_idle();

        // Periodic ch0, reload 3
        wr(4'h0, 8'h80); wr(4'h2, 8'h00); wr(4'h4, 8'h03); wr(4'h5, 8'h00); wr(4'h3, 8'h07);
        rd_chk("per_ctrl", 4'h0, 8'h80);
        rd_chk("per_cnt0", 4'h6, 8'h03);
        tick(); tick();
        rd_chk("per_t2_status", 4'h1, 8'h00);
        rd_chk("per_t2_cnt", 4'h6, 8'h01);
        chk("per_t2_int", 16'(sched_int), 16'h0);
        tick();
        rd_chk("per_t3_status", 4'h1, 8'h01);
        chk("per_t3_int", 16'(sched_int), 16'h1);
        rd_chk("per_t3_cnt", 4'h6, 8'h03);
        wr(4'h1, 8'h01);
        chk("w1c_int_lag", 16'(sched_int), 16'h1);
        @(negedge clk);
        chk("w1c_int_drop", 16'(sched_int), 16'h0);
        rd_chk("w1c_status", 4'h1, 8'h00);
        tick(); tick();
        rd_chk("per_t5_status", 4'h1, 8'h00);
        tick();
        rd_chk("per_t6_status", 4'h1, 8'h01);
        chk("per_t6_int", 16'(sched_int), 16'h1);
        tick();
        rd_chk("per_t7_cnt", 4'h6, 8'h02);
        wr(4'h1, 8'h01); wr(4'h3, 8'h00);

        // One-shot ch1 reload 2, periodic ch2 reload 0
        wr(4'h2, 8'h01); wr(4'h4, 8'h02); wr(4'h5, 8'h00); wr(4'h3, 8'h01);
        wr(4'h2, 8'h02); wr(4'h4, 8'h00); wr(4'h5, 8'h00); wr(4'h3, 8'h03);
        tick();
        rd_chk("os_t1_status", 4'h1, 8'h04);
        wr(4'h1, 8'h04);
        tick();
        rd_chk("os_t2_status", 4'h1, 8'h06);
        wr(4'h1, 8'h06);
        wr(4'h2, 8'h01);
        rd_chk("os_cfg1_cleared", 4'h3, 8'h00);
        tick();
        rd_chk("os_t3_status", 4'h1, 8'h04);
        wr(4'h1, 8'h04);
        tick();
        rd_chk("os_t4_status", 4'h1, 8'h04);
        chk("os_no_ien_int", 16'(sched_int), 16'h0);
        wr(4'h2, 8'h02);
        rd_chk("r0_cnt_l", 4'h6, 8'h01);
        rd_chk("r0_cnt_h", 4'h7, 8'h00);
        rd_chk("r0_cfg", 4'h3, 8'h03);
        wr(4'h1, 8'h04); wr(4'h3, 8'h00);

        // CHSEL out of range
        wr(4'h2, 8'h05); wr(4'h3, 8'h07);
        rd_chk("oor_chsel", 4'h2, 8'h05);
        rd_chk("oor_cfg", 4'h3, 8'h00);
        rd_chk("oor_cnt", 4'h6, 8'h00);

        // Overrun: two edges one cycle apart
        wr(4'h2, 8'h03); wr(4'h4, 8'h05); wr(4'h5, 8'h00); wr(4'h3, 8'h03);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        negs(10);
        rd_chk("ovr_one_scan", 4'h6, 8'h04);
        rd_chk("ovr_status", 4'h1, 8'h80);
        wr(4'h0, 8'h81);
        rd_chk("ovr_cleared", 4'h1, 8'h00);
        rd_chk("ovr_ctrl", 4'h0, 8'h80);
        wr(4'h3, 8'h00);

        // Collision: RELOAD_H write to ch0 while ch0 is scanned
        wr(4'h2, 8'h00); wr(4'h3, 8'h03); wr(4'h4, 8'h34);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        negs(3);
        bus_wr_set(4'h5, 8'h12);
        @(negedge clk); bus_idle();
        negs(8);
        rd_chk("col_rl_cnt_l", 4'h6, 8'h34);
        rd_chk("col_rl_cnt_h", 4'h7, 8'h12);
        rd_chk("col_rl_status", 4'h1, 8'h00);

        // Collision: W1C of PEND[0] while ch0 expires
        wr(4'h4, 8'h01); wr(4'h5, 8'h00);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        negs(3);
        bus_wr_set(4'h1, 8'h01);
        @(negedge clk); bus_idle();
        negs(8);
        rd_chk("col_w1c_pend", 4'h1, 8'h01);

        // Collision: OVR set and CTRL clear in the same cycle
        wr(4'h1, 8'h01);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        bus_wr_set(4'h0, 8'h81);
        @(negedge clk); bus_idle();
        negs(8);
        rd_chk("col_ovr_set_wins", 4'h1, 8'h81);
        wr(4'h0, 8'h81);
        rd_chk("col_ovr_cleared", 4'h1, 8'h01);
        wr(4'h1, 8'h01);

        // Ticks ignored with EN = 0
        wr(4'h0, 8'h00);
        tick();
        rd_chk("en0_status", 4'h1, 8'h00);

        // Reset during SCAN idx 2
        wr(4'h0, 8'h80); wr(4'h3, 8'h07);
        tick();
        chk("rst_pre_int", 16'(sched_int), 16'h1);
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        negs(5);
        chk("rst_pre_idx", 16'(dut.idx_q), 16'h2);
        chk("rst_pre_state", 16'(dut.state_q), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_state_idle", 16'(dut.state_q), 16'h0);
        chk("rst_int", 16'(sched_int), 16'h0);
        rst = 1'b0;
        rd_chk("rst_status", 4'h1, 8'h00);
        rd_chk("rst_ctrl", 4'h0, 8'h00);
        rd_chk("rst_cnt_l", 4'h6, 8'h00);
        rd_chk("rst_cfg", 4'h3, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
